// File: rtl/rs_bank_if.sv
// rs_bank_pkg / rs_bank_if
// Shared entry type and the bundled dispatch / CDB / issue signals of the
// multi-entry reservation station.
//   master : the surrounding pipeline. It drives dispatch, CDB and issue_ready.
//   slave  : the rs_bank. It drives accept, occupancy and issue.
// Optional feature macro used by rs_bank: RS_CDB_BYPASS_EN.
package rs_bank_pkg;
  localparam int PHYS_REGS = 128;
  localparam int TAG_W     = $clog2(PHYS_REGS);

  typedef struct packed {
    logic [7:0]       op;
    logic [5:0]       rob_idx;
    logic [TAG_W-1:0] dst_tag;
    logic [TAG_W-1:0] src1_tag;
    logic             src1_ready;
    logic [TAG_W-1:0] src2_tag;
    logic             src2_ready;
  } rs_entry_t;
endpackage

interface rs_bank_if #(
  parameter int RS_DEPTH    = 16,
  parameter int DISP_WIDTH  = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int CDB_WIDTH   = 2
);
  import rs_bank_pkg::*;

  logic [DISP_WIDTH-1:0]                disp_valid_i;
  rs_entry_t [DISP_WIDTH-1:0]           disp_pkt_i;
  logic [DISP_WIDTH-1:0]                disp_accept_o;
  logic [$clog2(RS_DEPTH+1)-1:0]        free_count_o;
  logic                                 empty_o;
  logic                                 full_o;
  logic [CDB_WIDTH-1:0]                 cdb_valid_i;
  logic [CDB_WIDTH-1:0][TAG_W-1:0]      cdb_tag_i;
  logic [ISSUE_WIDTH-1:0]               issue_ready_i;
  logic [ISSUE_WIDTH-1:0]               issue_valid_o;
  rs_entry_t [ISSUE_WIDTH-1:0]          issue_pkt_o;

  modport master (
    output disp_valid_i, disp_pkt_i, cdb_valid_i, cdb_tag_i, issue_ready_i,
    input  disp_accept_o, free_count_o, empty_o, full_o, issue_valid_o, issue_pkt_o
  );

  modport slave (
    input  disp_valid_i, disp_pkt_i, cdb_valid_i, cdb_tag_i, issue_ready_i,
    output disp_accept_o, free_count_o, empty_o, full_o, issue_valid_o, issue_pkt_o
  );
endinterface

// File: rtl/rs_bank.sv
// rs_bank
// Multi-entry reservation station with an age matrix for oldest-first select.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   flush : synchronous squash of every entry
//   bus   : rs_bank_if.slave. It carries dispatch in and accept out, the CDB
//           wakeup, issue valid/ready/pkt, and the occupancy flags.
// Build option: `define RS_CDB_BYPASS_EN lets a stored entry whose last
// missing source hits the CDB issue in that same cycle. Without it, only
// registered ready bits count toward eligibility.
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int RS_DEPTH    = 16,
  parameter int DISP_WIDTH  = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int CDB_WIDTH   = 2,
  parameter int PHYS_REGS   = 128
) (
  input logic     clock,
  input logic     reset,
  input logic     flush,
  rs_bank_if.slave bus
);

  localparam int TW    = $clog2(PHYS_REGS);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0] valid_q;
  rs_entry_t           entry_q [RS_DEPTH];
  // older_q[i][j] = entry i is older than entry j
  logic [RS_DEPTH-1:0] older_q [RS_DEPTH];

  function automatic logic tag_hit(
    input logic [TW-1:0]                 tag,
    input logic [CDB_WIDTH-1:0]          cv,
    input logic [CDB_WIDTH-1:0][TW-1:0]  ct
  );
    tag_hit = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++)
      if (cv[c] && (ct[c] == tag)) tag_hit = 1'b1;
  endfunction

  // A flush masks the CDB, so no wakeup is recorded in that cycle.
  logic [CDB_WIDTH-1:0]         cdb_valid;
  logic [CDB_WIDTH-1:0][TW-1:0] cdb_tag;
  assign cdb_valid = flush ? '0 : bus.cdb_valid_i;
  assign cdb_tag   = bus.cdb_tag_i;

  // Dispatch allocation. Valid slots are taken in order, and each one goes to
  // the lowest entry that is free in the registered state. prior_taken[k]
  // records which entries went to older slots in this cycle.
  logic [DISP_WIDTH-1:0]                 accept;
  logic [DISP_WIDTH-1:0][IDX_W-1:0]      slot_entry;
  logic [DISP_WIDTH-1:0][RS_DEPTH-1:0]   prior_taken;
  rs_entry_t [DISP_WIDTH-1:0]            disp_woken;

  always_comb begin
    logic [RS_DEPTH-1:0] taken;
    logic                found;
    taken       = '0;
    found       = 1'b0;
    accept      = '0;
    slot_entry  = '0;
    prior_taken = '0;
    disp_woken  = '0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      prior_taken[k] = taken;
      found          = 1'b0;
      if (bus.disp_valid_i[k] && !flush) begin
        for (int e = 0; e < RS_DEPTH; e++) begin
          if (!found && !valid_q[e] && !taken[e]) begin
            found         = 1'b1;
            slot_entry[k] = IDX_W'(e);
            taken[e]      = 1'b1;
          end
        end
      end
      accept[k]     = found;
      disp_woken[k] = bus.disp_pkt_i[k];
      if (tag_hit(bus.disp_pkt_i[k].src1_tag, cdb_valid, cdb_tag))
        disp_woken[k].src1_ready = 1'b1;
      if (tag_hit(bus.disp_pkt_i[k].src2_tag, cdb_valid, cdb_tag))
        disp_woken[k].src2_ready = 1'b1;
    end
  end

  // Wakeup and eligibility of the stored entries
  logic [RS_DEPTH-1:0] hit1, hit2, eligible;

  always_comb begin
    hit1     = '0;
    hit2     = '0;
    eligible = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      hit1[i] = tag_hit(entry_q[i].src1_tag, cdb_valid, cdb_tag);
      hit2[i] = tag_hit(entry_q[i].src2_tag, cdb_valid, cdb_tag);
`ifdef RS_CDB_BYPASS_EN
      eligible[i] = valid_q[i] && (entry_q[i].src1_ready || hit1[i])
                               && (entry_q[i].src2_ready || hit2[i]);
`else
      eligible[i] = valid_q[i] && entry_q[i].src1_ready && entry_q[i].src2_ready;
`endif
    end
  end

  // rank[i] is the number of eligible entries older than i. The age matrix is
  // a total order over the valid entries, so each rank maps to one entry.
  logic [CNT_W-1:0] rank [RS_DEPTH];

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      rank[i] = '0;
      for (int j = 0; j < RS_DEPTH; j++)
        if (eligible[j] && older_q[j][i]) rank[i] = rank[i] + CNT_W'(1);
    end
  end

  // Ready ports take ranks 0, 1, 2, ... in port order. A port that is not
  // ready does not use up a rank.
  logic [ISSUE_WIDTH-1:0]  issue_valid;
  rs_entry_t [ISSUE_WIDTH-1:0] issue_pkt;
  logic [RS_DEPTH-1:0]     grant;

  always_comb begin
    logic [CNT_W-1:0] r;
    rs_entry_t        sel_pkt;
    r           = '0;
    sel_pkt     = '0;
    issue_valid = '0;
    issue_pkt   = '0;
    grant       = '0;
    if (!flush) begin
      for (int p = 0; p < ISSUE_WIDTH; p++) begin
        if (bus.issue_ready_i[p]) begin
          for (int i = 0; i < RS_DEPTH; i++) begin
            if (eligible[i] && (rank[i] == r)) begin
              sel_pkt            = entry_q[i];
              sel_pkt.src1_ready = 1'b1;
              sel_pkt.src2_ready = 1'b1;
              issue_valid[p]     = 1'b1;
              issue_pkt[p]       = sel_pkt;
              grant[i]           = 1'b1;
            end
          end
          r = r + CNT_W'(1);
        end
      end
    end
  end

  logic [CNT_W-1:0] valid_cnt;

  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      valid_cnt = valid_cnt + CNT_W'(valid_q[i]);
  end

  assign bus.disp_accept_o = accept;
  assign bus.issue_valid_o = issue_valid;
  assign bus.issue_pkt_o   = issue_pkt;
  assign bus.free_count_o  = CNT_W'(RS_DEPTH) - valid_cnt;
  assign bus.full_o        = (bus.free_count_o == '0);
  assign bus.empty_o       = (bus.free_count_o == CNT_W'(RS_DEPTH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        entry_q[i] <= '0;
        older_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        // When an entry issues in the same cycle as its wakeup, the issue
        // takes priority and the entry is freed.
        if (grant[i]) begin
          valid_q[i] <= 1'b0;
        end else if (valid_q[i]) begin
          if (hit1[i]) entry_q[i].src1_ready <= 1'b1;
          if (hit2[i]) entry_q[i].src2_ready <= 1'b1;
        end
        for (int j = 0; j < RS_DEPTH; j++)
          if (grant[j]) older_q[i][j] <= 1'b0;
      end
      // A newly dispatched entry is younger than every entry that was valid
      // before it and every entry filled by an older slot in this cycle. It
      // was free in the registered state, so it cannot collide with a column
      // that is being cleared.
      for (int k = 0; k < DISP_WIDTH; k++) begin
        if (accept[k]) begin
          valid_q[slot_entry[k]] <= 1'b1;
          entry_q[slot_entry[k]] <= disp_woken[k];
          older_q[slot_entry[k]] <= '0;
          for (int j = 0; j < RS_DEPTH; j++)
            older_q[j][slot_entry[k]] <= valid_q[j] | prior_taken[k][j];
        end
      end
    end
  end

endmodule
